ksa: RTL and testbench

KSA -- requirements
Module: ksa

---
 rtl/arc4_pkg.sv | 18 +
 rtl/ksa.sv | 123 ++++++++++++
 tb/tb_ksa.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions used by the init, ksa and prga stages.
// Holds the key/S-array geometry and the key-scheduling state encoding.
package arc4_pkg;

  localparam int KEY_W   = 24;
  localparam int S_DEPTH = 256;

  typedef enum logic [2:0] {
    KSA_IDLE,
    KSA_RDI,
    KSA_WTI,
    KSA_RDJ,
    KSA_WTJ,
    KSA_WRI,
    KSA_WRJ
  } ksa_state_e;

endpackage

// File: rtl/ksa.sv
// ARC4 key-scheduling pass over an externally owned 256x8 S memory.
// One swap per six-cycle iteration: read S[i], read S[j], write both.
module ksa #(
  parameter int KEY_W   = arc4_pkg::KEY_W,
  parameter int S_DEPTH = arc4_pkg::S_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] key,
  output logic [7:0]       addr,
  input  logic [7:0]       rddata,
  output logic [7:0]       wrdata,
  output logic             wren
);

  import arc4_pkg::*;

  localparam logic [7:0] LAST_I = 8'(S_DEPTH - 1);

  ksa_state_e       state_q, state_d;
  logic [7:0]       i_q, i_d;
  logic [7:0]       j_q, j_d;
  logic [7:0]       si_q, si_d;
  logic [7:0]       sj_q, sj_d;
  logic [1:0]       ksel_q, ksel_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [7:0]       key_byte;

  // ksel tracks i mod 3 incrementally, avoiding a modulo-3 divider on i.
  always_comb begin
    unique case (ksel_q)
      2'd0:    key_byte = key_q[KEY_W-1 -: 8];
      2'd1:    key_byte = key_q[KEY_W-9 -: 8];
      default: key_byte = key_q[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= KSA_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      ksel_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      ksel_q  <= ksel_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    ksel_d  = ksel_q;
    key_d   = key_q;
    rdy     = 1'b0;
    addr    = '0;
    wrdata  = '0;
    wren    = 1'b0;

    unique case (state_q)
      KSA_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          state_d = KSA_RDI;
          key_d   = key;
          i_d     = '0;
          j_d     = '0;
          ksel_d  = '0;
        end
      end
      KSA_RDI: begin
        addr    = i_q;
        state_d = KSA_WTI;
      end
      KSA_WTI: begin
        si_d    = rddata;
        j_d     = j_q + rddata + key_byte;
        state_d = KSA_RDJ;
      end
      KSA_RDJ: begin
        addr    = j_q;
        state_d = KSA_WTJ;
      end
      KSA_WTJ: begin
        sj_d    = rddata;
        state_d = KSA_WRI;
      end
      KSA_WRI: begin
        addr    = i_q;
        wrdata  = sj_q;
        wren    = 1'b1;
        state_d = KSA_WRJ;
      end
      KSA_WRJ: begin
        addr   = j_q;
        wrdata = si_q;
        wren   = 1'b1;
        if (i_q == LAST_I) begin
          state_d = KSA_IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          ksel_d  = (ksel_q == 2'd2) ? 2'd0 : ksel_q + 2'd1;
          state_d = KSA_RDI;
        end
      end
      default: state_d = KSA_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: behavioural S memory, write log and an
// independent reference key schedule.
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  ksa #(.KEY_W(24), .S_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
    .addr(addr), .rddata(rddata), .wrdata(wrdata), .wren(wren)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic       mem_init = 1'b0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
  end

  logic [7:0] wa [512];
  logic [7:0] wd [512];
  int         wcnt = 0;
  logic       wclr = 1'b0;

  always @(posedge clk) begin
    if (wclr) begin
      wcnt <= 0;
    end else if (wren) begin
      if (wcnt < 512) begin
        wa[wcnt[8:0]] <= addr;
        wd[wcnt[8:0]] <= wrdata;
      end
      wcnt <= wcnt + 1;
    end
  end

  typedef struct {
    logic [23:0] key;
    int          iter;
    logic [7:0]  ai;
    logic [7:0]  di;
    logic [7:0]  aj;
    logic [7:0]  dj;
  } vec_t;

  vec_t       vt [8];
  logic [7:0] gold [256];
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prep(input logic do_init);
    mem_init = do_init;
    wclr = 1'b1;
    tick();
    mem_init = 1'b0;
    wclr = 1'b0;
  endtask

  task automatic gold_identity();
    for (int k = 0; k < 256; k++) gold[k] = 8'(k);
  endtask

  task automatic run_golden(input logic [23:0] k);
    logic [7:0] j;
    logic [7:0] t;
    logic [7:0] kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0:       kb = k[23:16];
        1:       kb = k[15:8];
        default: kb = k[7:0];
      endcase
      j = j + gold[i] + kb;
      t = gold[i];
      gold[i] = gold[j];
      gold[j] = t;
    end
  endtask

  task automatic compare_mem(input string tag);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== gold[k]) begin
        if (first < 0) first = k;
        bad++;
      end
    end
    if (bad != 0)
      $display("first differing S index %0d: mem=%0h ref=%0h", first, mem[first], gold[first]);
    check({tag, "_mem_diffs"}, 32'(bad), 32'd0);
  endtask

  // Starts a pass from idle; returns in cycle E+1.
  task automatic start_pass(input logic [23:0] k, input string tag);
    key = k;
    en = 1'b1;
    tick();
    en = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(rdy), 32'd0);
  endtask

  task automatic wait_rdy(input int budget, output int n);
    n = 0;
    while (rdy !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic check_table(input logic [23:0] k, input string tag);
    for (int v = 0; v < 8; v++) begin
      if (vt[v].key == k) begin
        check($sformatf("%s_it%0d_addr_i", tag, vt[v].iter), 32'(wa[2*vt[v].iter]),   32'(vt[v].ai));
        check($sformatf("%s_it%0d_data_i", tag, vt[v].iter), 32'(wd[2*vt[v].iter]),   32'(vt[v].di));
        check($sformatf("%s_it%0d_addr_j", tag, vt[v].iter), 32'(wa[2*vt[v].iter+1]), 32'(vt[v].aj));
        check($sformatf("%s_it%0d_data_j", tag, vt[v].iter), 32'(wd[2*vt[v].iter+1]), 32'(vt[v].dj));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;

    vt[0] = '{24'h000000, 0, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[1] = '{24'h000000, 1, 8'h01, 8'h01, 8'h01, 8'h01};
    vt[2] = '{24'h000000, 2, 8'h02, 8'h03, 8'h03, 8'h02};
    vt[3] = '{24'h000000, 3, 8'h03, 8'h05, 8'h05, 8'h02};
    vt[4] = '{24'h00033C, 0, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[5] = '{24'h00033C, 1, 8'h01, 8'h04, 8'h04, 8'h01};
    vt[6] = '{24'h00033C, 2, 8'h02, 8'h42, 8'h42, 8'h02};
    vt[7] = '{24'h00033C, 3, 8'h03, 8'h45, 8'h45, 8'h03};

    rst = 1'b1;
    en  = 1'b0;
    key = '0;
    @(negedge clk);
    tick();
    en = 1'b1;
    tick();
    check("rst_over_en_rdy", 32'(rdy), 32'd1);
    rst = 1'b0;
    en  = 1'b0;
    check("reset_rdy",    32'(rdy),    32'd1);
    check("reset_wren",   32'(wren),   32'd0);
    check("reset_addr",   32'(addr),   32'd0);
    check("reset_wrdata", 32'(wrdata), 32'd0);

    // Table-driven passes from an identity S.
    for (int p = 0; p < 2; p++) begin
      logic [23:0] k;
      string       tag;
      k   = (p == 0) ? 24'h000000 : 24'h00033C;
      tag = (p == 0) ? "key0" : "key33c";
      prep(1'b1);
      gold_identity();
      run_golden(k);
      start_pass(k, tag);
      wait_rdy(2000, n);
      check({tag, "_rdy_cycle"}, 32'(n + 1), 32'd1537);
      check({tag, "_write_count"}, 32'(wcnt), 32'd512);
      check_table(k, tag);
      compare_mem(tag);
    end

    // en/key churn while busy must not disturb the pass.
    prep(1'b1);
    gold_identity();
    run_golden(24'h00033C);
    start_pass(24'h00033C, "churn");
    for (int c = 0; c < 1400; c++) begin
      en  = 1'($urandom_range(0, 1));
      key = 24'($urandom);
      tick();
    end
    key = 24'hABCDEF;
    en  = 1'b1;
    wait_rdy(600, n);
    check("churn_rdy_cycle", 32'(n + 1401), 32'd1537);
    check("churn_write_count", 32'(wcnt), 32'd512);
    compare_mem("churn");

    // en still high: the very next edge starts a pass on the current S.
    key  = 24'h123456;
    wclr = 1'b1;
    run_golden(24'h123456);
    tick();
    wclr = 1'b0;
    en   = 1'b0;
    check("held_en_restart_busy", 32'(rdy), 32'd0);
    wait_rdy(2000, n);
    check("second_rdy_cycle", 32'(n + 1), 32'd1537);
    check("second_write_count", 32'(wcnt), 32'd512);
    compare_mem("second");

    // Reset in the middle of a pass.
    prep(1'b1);
    start_pass(24'h00033C, "abort");
    repeat (699) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rdy",    32'(rdy),    32'd1);
    check("abort_wren",   32'(wren),   32'd0);
    check("abort_addr",   32'(addr),   32'd0);
    check("abort_wrdata", 32'(wrdata), 32'd0);
    for (int k = 0; k < 256; k++) gold[k] = mem[k];
    w0 = wcnt;
    repeat (20) tick();
    check("abort_no_writes", 32'(wcnt), 32'(w0));
    check("abort_still_idle", 32'(rdy), 32'd1);
    compare_mem("abort_frozen");

    run_golden(24'h0A0B0C);
    prep(1'b0);
    start_pass(24'h0A0B0C, "restart");
    wait_rdy(2000, n);
    check("restart_rdy_cycle", 32'(n + 1), 32'd1537);
    check("restart_write_count", 32'(wcnt), 32'd512);
    compare_mem("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
